bit_serial_alu_ctrl: RTL and testbench
======================================

# bit_serial_alu_ctrl

Bit-serial sequencer that runs a WIDTH-bit operation through the team's 1-bit ALU, one bit per clock, LSB first. It sits directly upstream and downstream of the 1-bit ALU. It latches two operand words and an opcode, drives the ALU with one bit pair and the running carry/borrow each cycle, and collects its result bits. It produces the word-level result, carry/borrow out, zero flag and unsigned greater-than flag.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥2)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- opcode  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 NAND, 101 NOR; 110/111 invalid
- a  input  WIDTH  first operand
- b  input  WIDTH  second operand
- carryin  input  1  initial carry (ADD) or borrow (SUB); ignored for logic ops
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; result/flags valid from this cycle until next accepted start
- result  output  WIDTH  word result
- carryout  output  1  final carry (ADD) or borrow (SUB); 0 for logic ops
- zero  output  1  result == 0
- greater  output  1  a > b, unsigned
- err  output  1  last accepted opcode was invalid
- alu_opcode  output  3  to ALU opcode
- alu_input1  output  1  to ALU input1: current bit of a
- alu_input2  output  1  to ALU input2: current bit of b
- alu_carryin  output  1  to ALU carryin: running carry/borrow; 0 for logic ops
- alu_out  input  1  from ALU out
- alu_carryout  input  1  from ALU carryout (sum carry for ADD, borrow for SUB)
- alu_flag2  input  1  from ALU flag2 (input1 & ~input2)

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1, valid opcode:
  - latch a and b into shift registers and latch opcode.
  - carry reg <= carryin for 000/001, else 0.
  - clear bit counter, gt reg, result reg and nonzero accumulator; clear err.
  - go to RUN.
- IDLE, start=1, invalid opcode:
  - result <= 0, carryout <= 0, greater <= 0, zero <= 1, err <= 1.
  - go to DONE. No ALU cycles are run.
- RUN, every cycle:
  - alu_input1/alu_input2 are the current LSBs of the operand shift registers (combinational from registers); alu_carryin = carry reg.
  - At each edge: shift alu_out into result MSB (result shifts right); shift operands right.
  - ADD/SUB only: carry reg <= alu_carryout.
  - nonzero |= alu_out.
  - gt: set if alu_flag2; clear if (~bit_a & bit_b); else hold. Because bits run LSB first, the final value is the unsigned comparison a > b.
  - Increment the counter. When the counter reaches WIDTH-1: go to DONE, load the carryout and flag outputs, done <= 1.
- DONE: done high for this cycle only; next state IDLE. start is ignored in DONE.
- start is ignored in RUN. Operand and opcode inputs are not sampled after acceptance.
- alu_opcode = latched opcode in all states. ALU outputs are only sampled in RUN.
- Logic ops: alu_carryout is ignored and carryout is forced to 0.
- Outputs hold their last values in IDLE.
- reset (any state, including mid-RUN) at an edge:
  - state <= IDLE.
  - busy, done, result, carryout, zero, greater, err, carry reg and counter all <= 0.
  - The partial operation is discarded.

## Timing
- Start accepted at edge E0.
- Bit k is sampled at edge E0+k+1. The last bit is sampled at edge E0+WIDTH.
- done and results become visible after edge E0+WIDTH and are sampled high at edge E0+WIDTH+1.
- busy is high from after E0 until after E0+WIDTH, i.e. exactly WIDTH cycles.
- Invalid opcode: done is sampled high at edge E0+1; busy never rises.
- Minimum start-to-start spacing: WIDTH+2 cycles (valid) or 2 cycles (invalid).
- The ALU path is combinational within one cycle. There are no multicycle paths.

## Test plan
- WIDTH=8, ADD a=0xFF, b=0x01, carryin=0 -> result 0x00, carryout 1, zero 1, greater 1, err 0; done sampled high exactly at E0+9, busy high for 8 cycles.
- SUB a=0x05, b=0x07, carryin=0 -> result 0xFE, carryout (borrow) 1, zero 0, greater 0; SUB a=0x07, b=0x05, carryin=1 -> result 0x01, carryout 0, greater 1.
- AND a=0xF0, b=0x0F -> result 0x00, zero 1, carryout 0 even with alu_carryout stuck high; NOR a=0x00, b=0x00 -> result 0xFF, zero 0, greater 0.
- Opcode 3'b110 -> err 1, result 0x00, zero 1, done sampled high at E0+1, busy stays 0; a following valid ADD clears err.
- start pulsed during RUN (new a/b/opcode) -> ignored, original result unchanged; reset asserted at E0+4 -> all outputs 0 at next edge, no done pulse, next start runs normally.

Source files
------------

// File: rtl/bit_serial_alu_ctrl_if.sv
// Request/response bundle of the bit-serial ALU sequencer: operands and opcode in,
// word-level result and flags out.
interface bit_serial_alu_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carryin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             zero;
  logic             greater;
  logic             err;

  modport master (
    output start, opcode, a, b, carryin,
    input  busy, done, result, carryout, zero, greater, err
  );

  modport slave (
    input  start, opcode, a, b, carryin,
    output busy, done, result, carryout, zero, greater, err
  );
endinterface

// File: rtl/bit_serial_alu_ctrl.sv
// Runs a WIDTH-bit ADD/SUB/logic operation through an external 1-bit ALU, LSB first,
// one bit per clock, and assembles the word result plus carry, zero and a>b flags.
module bit_serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  bit_serial_alu_ctrl_if.slave bus,
  output logic [2:0]          alu_opcode,
  output logic                alu_input1,
  output logic                alu_input2,
  output logic                alu_carryin,
  input  logic                alu_out,
  input  logic                alu_carryout,
  input  logic                alu_flag2
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_NOR = 3'b101;

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [2:0]       op;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             gt;
  logic             nz;

  logic             arith;
  logic             gt_nxt;
  logic             nz_nxt;
  logic [WIDTH-1:0] res_nxt;

  assign alu_opcode  = op;
  assign alu_input1  = sa[0];
  assign alu_input2  = sb[0];
  assign alu_carryin = carry;

  // ADD (000) and SUB (001) are the only ops that propagate a carry/borrow.
  assign arith = (op[2:1] == 2'b00);

  // gt is decided by the most significant differing bit, which arrives last.
  always_comb begin
    gt_nxt  = gt;
    if (alu_flag2)
      gt_nxt = 1'b1;
    else if (!sa[0] && sb[0])
      gt_nxt = 1'b0;
    nz_nxt  = nz | alu_out;
    res_nxt = {alu_out, bus.result[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sa           <= '0;
      sb           <= '0;
      op           <= '0;
      carry        <= 1'b0;
      cnt          <= '0;
      gt           <= 1'b0;
      nz           <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.result   <= '0;
      bus.carryout <= 1'b0;
      bus.zero     <= 1'b0;
      bus.greater  <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.opcode <= OP_NOR) begin
              sa         <= bus.a;
              sb         <= bus.b;
              op         <= bus.opcode;
              carry      <= (bus.opcode[2:1] == 2'b00) ? bus.carryin : 1'b0;
              cnt        <= '0;
              gt         <= 1'b0;
              nz         <= 1'b0;
              bus.result <= '0;
              bus.err    <= 1'b0;
              bus.busy   <= 1'b1;
              state      <= RUN;
            end else begin
              bus.result   <= '0;
              bus.carryout <= 1'b0;
              bus.greater  <= 1'b0;
              bus.zero     <= 1'b1;
              bus.err      <= 1'b1;
              bus.done     <= 1'b1;
              state        <= DONE;
            end
          end
        end

        RUN: begin
          sa         <= sa >> 1;
          sb         <= sb >> 1;
          bus.result <= res_nxt;
          gt         <= gt_nxt;
          nz         <= nz_nxt;
          if (arith)
            carry <= alu_carryout;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            bus.carryout <= arith ? alu_carryout : 1'b0;
            bus.zero     <= ~nz_nxt;
            bus.greater  <= gt_nxt;
            state        <= DONE;
          end
        end

        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Scoreboard bench for bit_serial_alu_ctrl with a behavioural 1-bit ALU attached;
// expected words come from whole-word arithmetic, independent of the serial path.
module tb_bit_serial_alu_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] result;
    logic         carryout;
    logic         zero;
    logic         greater;
    logic         err;
  } exp_t;

  logic clk;
  logic reset;
  logic [2:0] alu_opcode;
  logic alu_input1, alu_input2, alu_carryin;
  logic alu_out, alu_carryout, alu_flag2;
  logic alu_cout_model;
  logic force_cout;

  int n_cmp;
  int n_err;
  exp_t sb_q[$];

  bit_serial_alu_ctrl_if #(.WIDTH(W)) bus ();

  bit_serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .alu_opcode   (alu_opcode),
    .alu_input1   (alu_input1),
    .alu_input2   (alu_input2),
    .alu_carryin  (alu_carryin),
    .alu_out      (alu_out),
    .alu_carryout (alu_carryout),
    .alu_flag2    (alu_flag2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 1-bit ALU.
  always_comb begin
    alu_out        = 1'b0;
    alu_cout_model = 1'b0;
    case (alu_opcode)
      3'd0: begin
        alu_out        = alu_input1 ^ alu_input2 ^ alu_carryin;
        alu_cout_model = (alu_input1 & alu_input2) | (alu_carryin & (alu_input1 ^ alu_input2));
      end
      3'd1: begin
        alu_out        = alu_input1 ^ alu_input2 ^ alu_carryin;
        alu_cout_model = (~alu_input1 & alu_input2) | (~(alu_input1 ^ alu_input2) & alu_carryin);
      end
      3'd2: alu_out = alu_input1 & alu_input2;
      3'd3: alu_out = alu_input1 | alu_input2;
      3'd4: alu_out = ~(alu_input1 & alu_input2);
      3'd5: alu_out = ~(alu_input1 | alu_input2);
      default: alu_out = 1'b0;
    endcase
  end
  assign alu_carryout = force_cout ? 1'b1 : alu_cout_model;
  assign alu_flag2    = alu_input1 & ~alu_input2;

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic c);
    exp_t e;
    logic [W:0] w;
    e = '0;
    w = '0;
    case (op)
      3'd0: begin w = {1'b0, x} + {1'b0, y} + (W+1)'(c); e.result = w[W-1:0]; e.carryout = w[W]; end
      3'd1: begin w = {1'b0, x} - {1'b0, y} - (W+1)'(c); e.result = w[W-1:0]; e.carryout = w[W]; end
      3'd2: e.result = x & y;
      3'd3: e.result = x | y;
      3'd4: e.result = ~(x & y);
      3'd5: e.result = ~(x | y);
      default: begin
        e.err  = 1'b1;
        e.zero = 1'b1;
        return e;
      end
    endcase
    e.zero    = (e.result == '0);
    e.greater = (x > y);
    return e;
  endfunction

  // Drives a request in IDLE; returns at the falling edge just after the accepting edge.
  task automatic start_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input bit push);
    bus.start   = 1'b1;
    bus.opcode  = op;
    bus.a       = x;
    bus.b       = y;
    bus.carryin = c;
    if (push) sb_q.push_back(model(op, x, y, c));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Watches for done (bounded); k counts edges after the accepting edge. Optionally
  // pulses start with unrelated operands at k == inject_k. Ends with the FSM in IDLE.
  task automatic wait_done(input int inject_k, output int done_k, output int busy_cnt,
                           output exp_t obs, output logic done_after);
    done_k   = -1;
    busy_cnt = 0;
    obs      = '0;
    for (int k = 0; k < 40; k++) begin
      if (k == inject_k) begin
        bus.start = 1'b1; bus.opcode = 3'd1; bus.a = 8'hAA; bus.b = 8'h55; bus.carryin = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_k = k;
        obs    = {bus.result, bus.carryout, bus.zero, bus.greater, bus.err};
        break;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    @(negedge clk);
    done_after = bus.done;
  endtask

  task automatic test_reset();
    logic [W+8:0] got;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    got = {bus.busy, bus.done, bus.result, bus.carryout, bus.zero, bus.greater, bus.err,
           alu_opcode, alu_carryin};
    n_cmp++;
    if (got !== '0) begin
      n_err++;
      $display("FAIL reset_state: got %h, expected 0", got);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    exp_t e, obs;
    int dk, bc;
    logic da;
    start_op(3'd0, 8'hFF, 8'h01, 1'b0, 1'b1);
    wait_done(-1, dk, bc, obs, da);
    e = sb_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL add_ff_01: got %h, expected %h", obs, e); end
    n_cmp++;
    if (dk !== W) begin n_err++; $display("FAIL add_done_edge: got E0+%0d, expected E0+%0d", dk + 1, W + 1); end
    n_cmp++;
    if (bc !== W) begin n_err++; $display("FAIL add_busy_cycles: got %0d, expected %0d", bc, W); end
    n_cmp++;
    if (da !== 1'b0) begin n_err++; $display("FAIL add_done_pulse: done after pulse %b, expected 0", da); end
  endtask

  task automatic test_sub();
    exp_t e, obs;
    int dk, bc;
    logic da;
    start_op(3'd1, 8'h05, 8'h07, 1'b0, 1'b1);
    wait_done(-1, dk, bc, obs, da);
    e = sb_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL sub_05_07: got %h, expected %h", obs, e); end
    start_op(3'd1, 8'h07, 8'h05, 1'b1, 1'b1);
    wait_done(-1, dk, bc, obs, da);
    e = sb_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL sub_07_05_bin: got %h, expected %h", obs, e); end
  endtask

  task automatic test_logic();
    exp_t e, obs;
    int dk, bc;
    logic da;
    force_cout = 1'b1;
    start_op(3'd2, 8'hF0, 8'h0F, 1'b1, 1'b1);
    wait_done(-1, dk, bc, obs, da);
    force_cout = 1'b0;
    e = sb_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL and_cout_stuck: got %h, expected %h", obs, e); end
    start_op(3'd5, 8'h00, 8'h00, 1'b0, 1'b1);
    wait_done(-1, dk, bc, obs, da);
    e = sb_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL nor_00_00: got %h, expected %h", obs, e); end
    start_op(3'd3, 8'hA0, 8'h05, 1'b0, 1'b1);
    wait_done(-1, dk, bc, obs, da);
    e = sb_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL or_a0_05: got %h, expected %h", obs, e); end
  endtask

  task automatic test_invalid();
    exp_t e, obs;
    int dk, bc;
    logic da;
    start_op(3'b110, 8'h12, 8'h34, 1'b1, 1'b1);
    wait_done(-1, dk, bc, obs, da);
    e = sb_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL invalid_flags: got %h, expected %h", obs, e); end
    n_cmp++;
    if (dk !== 0) begin n_err++; $display("FAIL invalid_done_edge: got E0+%0d, expected E0+1", dk + 1); end
    n_cmp++;
    if (bc !== 0) begin n_err++; $display("FAIL invalid_busy: got %0d busy cycles, expected 0", bc); end
    start_op(3'd0, 8'h12, 8'h34, 1'b0, 1'b1);
    wait_done(-1, dk, bc, obs, da);
    e = sb_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL add_clears_err: got %h, expected %h", obs, e); end
  endtask

  task automatic test_start_during_run();
    exp_t e, obs;
    int dk, bc;
    logic da;
    start_op(3'd0, 8'h10, 8'h20, 1'b0, 1'b1);
    wait_done(3, dk, bc, obs, da);
    e = sb_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL start_in_run: got %h, expected %h", obs, e); end
    n_cmp++;
    if (dk !== W) begin n_err++; $display("FAIL start_in_run_edge: got E0+%0d, expected E0+%0d", dk + 1, W + 1); end
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL start_in_run_idle: busy %b, expected 0", bus.busy); end
  endtask

  task automatic test_reset_mid_run();
    exp_t e, obs;
    int dk, bc, spurious;
    logic da;
    logic [W+5:0] got;
    start_op(3'd0, 8'h3C, 8'h0F, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    got = {bus.busy, bus.done, bus.result, bus.carryout, bus.zero, bus.greater, bus.err};
    n_cmp++;
    if (got !== '0) begin n_err++; $display("FAIL reset_mid_run: got %h, expected 0", got); end
    reset = 1'b0;
    spurious = 0;
    for (int k = 0; k < 15; k++) begin
      if (bus.done || bus.busy) spurious++;
      @(negedge clk);
    end
    n_cmp++;
    if (spurious !== 0) begin n_err++; $display("FAIL reset_no_done: got %0d active cycles, expected 0", spurious); end
    start_op(3'd0, 8'h3C, 8'h0F, 1'b1, 1'b1);
    wait_done(-1, dk, bc, obs, da);
    e = sb_q.pop_front();
    n_cmp++;
    if (obs !== e) begin n_err++; $display("FAIL after_reset_add: got %h, expected %h", obs, e); end
  endtask

  task automatic test_back_to_back();
    exp_t e, obs;
    int dk, bc;
    logic da;
    logic [2:0] op;
    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(0, 7));
      start_op(op, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      wait_done(-1, dk, bc, obs, da);
      e = sb_q.pop_front();
      n_cmp++;
      if (obs !== e) begin n_err++; $display("FAIL b2b_%0d_op%0d: got %h, expected %h", i, op, obs, e); end
      n_cmp++;
      if (dk !== ((op > 3'd5) ? 0 : W)) begin
        n_err++;
        $display("FAIL b2b_%0d_edge: got E0+%0d, expected E0+%0d", i, dk + 1, (op > 3'd5) ? 1 : W + 1);
      end
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    reset       = 1'b1;
    force_cout  = 1'b0;
    bus.start   = 1'b0;
    bus.opcode  = '0;
    bus.a       = '0;
    bus.b       = '0;
    bus.carryin = 1'b0;
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_invalid();
    test_start_during_run();
    test_reset_mid_run();
    test_back_to_back();
    n_cmp++;
    if (sb_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
